prng_stream_monitor: RTL and testbench
======================================

Name: prng_stream_monitor

Overview:
- Downstream consumer of the integer PRNG stage (lcg_prng / mt8_prng / lfsr). It takes prng_data qualified by prng_done and measures the generator in hardware.
- Captures a reference sample, counts accepted samples until that value recurs, and reports the period.
- Also reports a total one-bit count (bias check) and flags stuck and timeout conditions.
- Replaces bench-side period detection so it can run on silicon or FPGA.

Parameters:
- N, 8, width of prng_data
- CNT_W, 32, width of period, sample and ones counters
- MAX_SAMPLES, 300, monitored-sample limit before timeout (must be < 2^CNT_W)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins (or restarts) a measurement
- prng_data  in  N  sample from the PRNG
- prng_valid  in  1  sample qualifier; driven by PRNG prng_done
- busy  out  1  high in CAPTURE or MONITOR
- done  out  1  high in DONE; held until next start
- period_found  out  1  reference value recurred
- stuck  out  1  recurrence on the first monitored sample (period 1)
- timeout  out  1  MAX_SAMPLES monitored with no recurrence
- period  out  CNT_W  monitored samples up to and including the match; 0 if timeout
- sample_count  out  CNT_W  total accepted samples, including the reference sample
- ones_count  out  CNT_W  sum of popcount over all accepted samples

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - All outputs and internal registers go to 0, including first_value and mon_cnt.
- States: IDLE, CAPTURE, MONITOR, DONE. All outputs are registered.
- IDLE:
  - start=1 moves to CAPTURE.
  - The same edge clears period, sample_count, ones_count and mon_cnt, and clears all flags.
- CAPTURE:
  - The first cycle with prng_valid=1 latches first_value <= prng_data.
  - On that cycle: sample_count <= 1 and ones_count <= popcount(prng_data); move to MONITOR.
  - Cycles with prng_valid=0 are ignored.
- MONITOR, on each prng_valid=1 cycle:
  - mon_cnt increments.
  - sample_count increments.
  - ones_count accumulates popcount(prng_data).
  - If prng_data == first_value:
    - period <= mon_cnt+1 and period_found <= 1.
    - stuck <= 1 if mon_cnt+1 == 1.
    - Move to DONE.
  - Else if mon_cnt+1 == MAX_SAMPLES: timeout <= 1, period <= 0, move to DONE.
  - A match on the MAX_SAMPLES-th sample counts as a match: period_found wins and timeout stays 0.
- DONE:
  - done=1 and busy=0.
  - All results are held; further prng_valid is ignored.
- start while in CAPTURE, MONITOR or DONE: abort or restart. Clear as in IDLE and go to CAPTURE on the same edge. start takes priority over a coincident valid sample.
- Latency: done, period_found, stuck and timeout assert on the clock edge that accepts the deciding sample. They are visible the same cycle that state reads DONE.
- Counters saturate at 2^CNT_W-1; they never wrap.
- prng_data is only sampled when prng_valid=1. X on prng_data while prng_valid=0 has no effect.

Decomposition:
- Shared package prng_pkg:
  - state enum (IDLE, CAPTURE, MONITOR, DONE) and the 2-bit state width constant.
  - popcount function, parameterised on N.
  - Default N constant reused by the PRNG stages.
- No sub-module needed; popcount is the package function. An optional popcount_n combinational helper is allowed if synthesis timing demands it.

Test Plan:
- Period 3:
  - Stimulus: start, then valid samples 42,17,99,42 back-to-back.
  - Response: done=1, period_found=1, period=3, sample_count=4, ones_count=12 (3+2+4+3), stuck=0, timeout=0.
- Valid gaps:
  - Stimulus: same sequence with 0–3 idle cycles (prng_valid=0, prng_data random) between samples.
  - Response: identical results to the period-3 case; done rises on the edge accepting the final 42.
- Stuck generator:
  - Stimulus: start, samples 5,5.
  - Response: period_found=1, stuck=1, period=1, sample_count=2, ones_count=4.
- Timeout:
  - Stimulus: reference 0, then 300 monitored samples cycling 1..255 (never 0).
  - Response: timeout=1, period_found=0, period=0, sample_count=301; done is held while further samples are ignored.
- Async reset mid-MONITOR:
  - Stimulus: after 42,17, assert reset=0 between clock edges.
  - Response: all outputs 0 immediately, state IDLE. After release, a new start followed by 7,9,7 gives period=2.
- Restart from DONE and mid-run:
  - Stimulus: start pulse in DONE, then 8,1,8; separately, start during MONITOR.
  - Response: results cleared on the start edge. The restart in DONE reports period=2, sample_count=3. The restart during MONITOR discards the old first_value.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared types and helpers for the integer PRNG stages
// and their downstream stream monitor.
package prng_pkg;

  localparam int N_DEFAULT = 8;
  localparam int STATE_W   = 2;
  localparam int POP_W     = 64;
  localparam int POPCNT_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    MONITOR = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Callers zero-extend their N-bit sample to POP_W.
  function automatic logic [POPCNT_W-1:0] popcount(
    input logic [POP_W-1:0] v
  );
    logic [POPCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_W; i++) begin
      c = c + POPCNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prng_stream_monitor.sv
// Measures period, sample count and one-bit bias of a
// PRNG stream qualified by prng_valid.
module prng_stream_monitor
  import prng_pkg::*;
#(
  parameter int N           = N_DEFAULT,
  parameter int CNT_W       = 32,
  parameter int MAX_SAMPLES = 300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     prng_data,
  input  logic             prng_valid,
  output logic             busy,
  output logic             done,
  output logic             period_found,
  output logic             stuck,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] ones_count
);

  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(MAX_SAMPLES);

  state_t              state;
  logic [N-1:0]        first_value;
  logic [CNT_W-1:0]    mon_cnt;

  logic [POPCNT_W-1:0] pop;
  logic [CNT_W:0]      ones_sum;
  logic [CNT_W-1:0]    ones_nxt;
  logic [CNT_W-1:0]    sample_nxt;
  logic [CNT_W-1:0]    mon_nxt;
  logic                match;

  // Saturating next values for all counters.
  always_comb begin
    pop        = popcount(POP_W'(prng_data));
    ones_sum   = {1'b0, ones_count}
               + (CNT_W+1)'(pop);
    ones_nxt   = ones_sum[CNT_W] ? '1
               : ones_sum[CNT_W-1:0];
    sample_nxt = (&sample_count) ? sample_count
               : sample_count + 1'b1;
    mon_nxt    = (&mon_cnt) ? mon_cnt
               : mon_cnt + 1'b1;
    match      = (prng_data == first_value);
  end

  // Measurement FSM with registered results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      first_value  <= '0;
      mon_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      period_found <= 1'b0;
      stuck        <= 1'b0;
      timeout      <= 1'b0;
      period       <= '0;
      sample_count <= '0;
      ones_count   <= '0;
    end else if (start) begin
      state        <= CAPTURE;
      mon_cnt      <= '0;
      busy         <= 1'b1;
      done         <= 1'b0;
      period_found <= 1'b0;
      stuck        <= 1'b0;
      timeout      <= 1'b0;
      period       <= '0;
      sample_count <= '0;
      ones_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
        end
        CAPTURE: begin
          if (prng_valid) begin
            first_value  <= prng_data;
            sample_count <= CNT_W'(1);
            ones_count   <= CNT_W'(pop);
            state        <= MONITOR;
          end
        end
        MONITOR: begin
          if (prng_valid) begin
            mon_cnt      <= mon_nxt;
            sample_count <= sample_nxt;
            ones_count   <= ones_nxt;
            if (match) begin
              period       <= mon_nxt;
              period_found <= 1'b1;
              stuck        <= (mon_nxt == CNT_W'(1));
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end else if (mon_nxt == MAX_CNT) begin
              timeout <= 1'b1;
              period  <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prng_stream_monitor.sv
// Directed bench for prng_stream_monitor with a
// sample-history reference model.
module tb_prng_stream_monitor;

  localparam int N     = 8;
  localparam int CNT_W = 32;
  localparam int MAXS  = 300;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [N-1:0]     prng_data = '0;
  logic             prng_valid = 1'b0;
  logic             busy, done, period_found;
  logic             stuck, timeout;
  logic [CNT_W-1:0] period, sample_count, ones_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prng_stream_monitor #(
    .N(N), .CNT_W(CNT_W), .MAX_SAMPLES(MAXS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .prng_data(prng_data),
    .prng_valid(prng_valid),
    .busy(busy),
    .done(done),
    .period_found(period_found),
    .stuck(stuck),
    .timeout(timeout),
    .period(period),
    .sample_count(sample_count),
    .ones_count(ones_count)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 waiting ref, 2 monitoring, 3 done.
  int           m_phase = 0;
  logic [N-1:0] m_q[$];
  bit           m_found = 0;
  bit           m_tout = 0;
  int           m_period = 0;

  function automatic void m_clear();
    m_q.delete();
    m_found = 0;
    m_tout = 0;
    m_period = 0;
    m_phase = 0;
  endfunction

  initial begin
    logic         s_start, s_valid, s_rst;
    logic [N-1:0] s_data;
    int           ones;
    forever begin
      @(posedge clk);
      s_start = start;
      s_valid = prng_valid;
      s_data  = prng_data;
      s_rst   = reset;
      #1;
      if (!s_rst || !reset) begin
        m_clear();
      end else if (s_start) begin
        m_clear();
        m_phase = 1;
      end else if (s_valid &&
                   (m_phase == 1 || m_phase == 2)) begin
        m_q.push_back(s_data);
        if (m_q.size() == 1) begin
          m_phase = 2;
        end else if (s_data == m_q[0]) begin
          m_found = 1;
          m_period = m_q.size() - 1;
          m_phase = 3;
        end else if (m_q.size() - 1 == MAXS) begin
          m_tout = 1;
          m_phase = 3;
        end
      end
      ones = 0;
      foreach (m_q[i]) ones += $countones(m_q[i]);
      chk("cyc.busy", 64'(busy),
          64'(m_phase == 1 || m_phase == 2));
      chk("cyc.done", 64'(done), 64'(m_phase == 3));
      chk("cyc.found", 64'(period_found), 64'(m_found));
      chk("cyc.stuck", 64'(stuck),
          64'(m_found && m_period == 1));
      chk("cyc.timeout", 64'(timeout), 64'(m_tout));
      chk("cyc.period", 64'(period), 64'(m_period));
      chk("cyc.samples", 64'(sample_count),
          64'(m_q.size()));
      chk("cyc.ones", 64'(ones_count), 64'(ones));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      prng_valid = 1'b0;
      prng_data = N'($urandom);
    end
  endtask

  task automatic send(input logic [N-1:0] d);
    @(negedge clk);
    start = 1'b0;
    prng_valid = 1'b1;
    prng_data = d;
  endtask

  task automatic pulse(input bit v,
                       input logic [N-1:0] d);
    @(negedge clk);
    start = 1'b1;
    prng_valid = v;
    prng_data = d;
  endtask

  task automatic res(input string nm,
                     input bit pf, input bit st,
                     input bit to, input int per,
                     input int sc, input int oc);
    int k;
    idle(1);
    k = 0;
    while (!done && k < 20) begin
      idle(1);
      k++;
    end
    chk({nm, ".bound"}, 64'(k < 20), 64'(1));
    chk({nm, ".done"}, 64'(done), 64'(1));
    chk({nm, ".busy"}, 64'(busy), 64'(0));
    chk({nm, ".found"}, 64'(period_found), 64'(pf));
    chk({nm, ".stuck"}, 64'(stuck), 64'(st));
    chk({nm, ".timeout"}, 64'(timeout), 64'(to));
    chk({nm, ".period"}, 64'(period), 64'(per));
    chk({nm, ".samples"}, 64'(sample_count), 64'(sc));
    chk({nm, ".ones"}, 64'(ones_count), 64'(oc));
  endtask

  task automatic all_zero(input string nm);
    chk({nm, ".busy"}, 64'(busy), 64'(0));
    chk({nm, ".done"}, 64'(done), 64'(0));
    chk({nm, ".found"}, 64'(period_found), 64'(0));
    chk({nm, ".stuck"}, 64'(stuck), 64'(0));
    chk({nm, ".timeout"}, 64'(timeout), 64'(0));
    chk({nm, ".period"}, 64'(period), 64'(0));
    chk({nm, ".samples"}, 64'(sample_count), 64'(0));
    chk({nm, ".ones"}, 64'(ones_count), 64'(0));
  endtask

  initial begin
    logic [N-1:0] seq3 [4];
    seq3 = '{8'd42, 8'd17, 8'd99, 8'd42};

    idle(3);
    all_zero("rst");
    reset = 1'b1;
    idle(2);
    send(8'd42);
    idle(2);
    all_zero("idle_ignore");

    pulse(0, 8'd0);
    foreach (seq3[i]) send(seq3[i]);
    res("p3", 1, 0, 0, 3, 4, 12);
    send(8'd42);
    send(8'd17);
    idle(1);
    chk("p3.hold", 64'(sample_count), 64'(4));

    pulse(0, 8'd0);
    foreach (seq3[i]) begin
      idle($urandom_range(0, 3));
      send(seq3[i]);
    end
    res("gaps", 1, 0, 0, 3, 4, 12);

    pulse(0, 8'd0);
    send(8'd5);
    send(8'd5);
    res("stuck", 1, 1, 0, 1, 2, 4);

    pulse(0, 8'd0);
    send(8'd0);
    for (int i = 0; i < MAXS; i++)
      send(N'((i % 255) + 1));
    res("tout", 0, 0, 1, 0, 301, 1143);
    send(8'd0);
    send(8'd3);
    idle(2);
    chk("tout.hold_done", 64'(done), 64'(1));
    chk("tout.hold_found", 64'(period_found), 64'(0));
    chk("tout.hold_samples", 64'(sample_count),
        64'(301));

    pulse(0, 8'd0);
    send(8'd0);
    for (int i = 0; i < MAXS - 1; i++)
      send(N'((i % 255) + 1));
    send(8'd0);
    res("edge", 1, 0, 0, 300, 301, 1139);

    pulse(0, 8'd0);
    send(8'd42);
    send(8'd17);
    @(negedge clk);
    prng_valid = 1'b0;
    #2 reset = 1'b0;
    #1 all_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    pulse(0, 8'd0);
    send(8'd7);
    send(8'd9);
    send(8'd7);
    res("post_rst", 1, 0, 0, 2, 3, 8);

    pulse(0, 8'd0);
    idle(1);
    chk("rs_done.busy", 64'(busy), 64'(1));
    chk("rs_done.done", 64'(done), 64'(0));
    chk("rs_done.found", 64'(period_found), 64'(0));
    chk("rs_done.period", 64'(period), 64'(0));
    chk("rs_done.samples", 64'(sample_count), 64'(0));
    send(8'd8);
    send(8'd1);
    send(8'd8);
    res("rs_done", 1, 0, 0, 2, 3, 3);

    pulse(0, 8'd0);
    send(8'd42);
    send(8'd17);
    pulse(1, 8'd42);
    send(8'd17);
    send(8'd42);
    send(8'd3);
    send(8'd17);
    res("rs_mon", 1, 0, 0, 3, 4, 9);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
